line_window_scheduler: RTL and testbench

- Frame-level controller that sequences the 3-row sliding window feeding the 3x3 kernel.
- Walks rows 0..ROWS-1 of a frame in order and fetches each line from frame memory over a req/ack handshake.
- Commands the window to shift in memory data or zero lines, so the top border is zero at row 0 and the bottom border is zero at the last row.
- Presents each window to the kernel and advances only after the kernel reports done.
- Sits between the frame-memory read port, the window registers and the kernel stage.

---
 rtl/lws_pkg.sv | 17 +
 rtl/line_window_scheduler.sv | 132 +++++++++++++
 tb/tb_line_window_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lws_pkg.sv
// Shared types and default sizes for the line window scheduler.
package lws_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FETCH,
      PRESENT,
      ZFILL,
      DONE
   } state_t;

   localparam int FRAME_ROWS = 720;
   localparam int ROW_ADDR_W = 10;
   localparam int LINE_BITS  = 1280;

endpackage

// File: rtl/line_window_scheduler.sv
// Frame controller sequencing the 3-row window: fetches lines, injects zero borders, hands rows to the kernel.
// Optional LWS_STALL_CNT_EN adds a per-frame memory stall counter output (stall_cycles).
module line_window_scheduler
   import lws_pkg::*;
#(
   parameter int ROWS   = FRAME_ROWS,
   parameter int ROW_W  = ROW_ADDR_W,
   parameter int LINE_W = LINE_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic              mem_req,
   output logic [ROW_W-1:0]  mem_addr,
   input  logic              mem_ack,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              win_shift,
   output logic [LINE_W-1:0] win_line,
   output logic              win_valid,
   output logic [ROW_W-1:0]  calc_row,
   input  logic              kernel_done
`ifdef LWS_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] PENULT_ROW = ROW_W'(ROWS - 2);

   state_t           state_reg, state_next;
   logic [ROW_W-1:0] fetch_row_reg, fetch_row_next;
   logic [ROW_W-1:0] calc_row_reg, calc_row_next;
   logic             busy_reg, frame_done_reg, mem_req_reg, win_valid_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         fetch_row_reg  <= '0;
         calc_row_reg   <= '0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
         mem_req_reg    <= 1'b0;
         win_valid_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         fetch_row_reg  <= fetch_row_next;
         calc_row_reg   <= calc_row_next;
         busy_reg       <= (state_next != IDLE);
         frame_done_reg <= (state_next == DONE);
         mem_req_reg    <= (state_next == FETCH);
         win_valid_reg  <= (state_next == PRESENT);
      end
   end

   always_comb begin
      state_next     = state_reg;
      fetch_row_next = fetch_row_reg;
      calc_row_next  = calc_row_reg;
      win_shift      = 1'b0;
      win_line       = '0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = CLEAR;
         end
         CLEAR: begin
            // Zero line becomes the top border once rows 0 and 1 have been shifted in.
            win_shift      = 1'b1;
            fetch_row_next = '0;
            calc_row_next  = '0;
            state_next     = FETCH;
         end
         FETCH: begin
            if (mem_ack) begin
               win_shift      = 1'b1;
               win_line       = mem_rdata;
               fetch_row_next = fetch_row_reg + ROW_W'(1);
               state_next     = (fetch_row_reg == '0) ? FETCH : PRESENT;
            end
         end
         PRESENT: begin
            if (kernel_done) begin
               if (calc_row_reg == LAST_ROW) begin
                  state_next = DONE;
               end else if (calc_row_reg == PENULT_ROW) begin
                  state_next = ZFILL;
               end else begin
                  state_next    = FETCH;
                  calc_row_next = calc_row_reg + ROW_W'(1);
               end
            end
         end
         ZFILL: begin
            win_shift     = 1'b1;
            calc_row_next = LAST_ROW;
            state_next    = PRESENT;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy       = busy_reg;
   assign frame_done = frame_done_reg;
   assign mem_req    = mem_req_reg;
   assign mem_addr   = fetch_row_reg;
   assign win_valid  = win_valid_reg;
   assign calc_row   = calc_row_reg;

`ifdef LWS_STALL_CNT_EN
   logic [31:0] stall_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_reg <= '0;
      end else if (state_reg == CLEAR) begin
         stall_reg <= '0;
      end else if (mem_req_reg && !mem_ack && (stall_reg != '1)) begin
         stall_reg <= stall_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_line_window_scheduler.sv
// Scoreboard bench for line_window_scheduler: ROWS=4 and ROWS=2 instances driven one at a time.
module tb_line_window_scheduler;

   typedef struct packed {
      logic [1:0]  dut;
      logic [1:0]  kind;   // 0 shift, 1 present, 2 frame done
      logic [15:0] val;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   logic start_a [2];
   logic busy_a [2];
   logic fd_a [2];
   logic req_a [2];
   logic ack_a [2];
   logic shift_a [2];
   logic valid_a [2];
   logic kd_a [2];
   logic kd_force [2];
   logic [9:0]  addr_a [2];
   logic [9:0]  crow_a [2];
   logic [15:0] rdata_a [2];
   logic [15:0] line_a [2];
`ifdef LWS_STALL_CNT_EN
   logic [31:0] stall_a [2];
`endif

   logic [9:0] delay_row;
   int         delay_n;
   ev_t        exp_q [$];
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   task automatic check_event(input int d, input int k, input logic [15:0] v);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event dut=%0d actual kind=%0d val=%h required=no event", d, k, v);
      end else begin
         e = exp_q.pop_front();
         if (e.dut != 2'(d) || e.kind != 2'(k) || e.val != v) begin
            errors++;
            $display("FAIL event dut=%0d actual kind=%0d val=%h required dut=%0d kind=%0d val=%h",
                     d, k, v, e.dut, e.kind, e.val);
         end else begin
            $display("txn dut=%0d kind=%0d val=%h ok", d, k, v);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end else begin
         $display("check %s = %0d ok", name, act);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int NR = (gi == 0) ? 4 : 2;
      int   wait_cnt;
      int   kcnt;
      logic prev_valid;

      line_window_scheduler #(.ROWS(NR), .ROW_W(10), .LINE_W(16)) u_dut (
         .clk         (clk),
         .rst         (rst),
         .start       (start_a[gi]),
         .busy        (busy_a[gi]),
         .frame_done  (fd_a[gi]),
         .mem_req     (req_a[gi]),
         .mem_addr    (addr_a[gi]),
         .mem_ack     (ack_a[gi]),
         .mem_rdata   (rdata_a[gi]),
         .win_shift   (shift_a[gi]),
         .win_line    (line_a[gi]),
         .win_valid   (valid_a[gi]),
         .calc_row    (crow_a[gi]),
         .kernel_done (kd_a[gi])
`ifdef LWS_STALL_CNT_EN
         ,
         .stall_cycles(stall_a[gi])
`endif
      );

      // Memory answers in the request cycle except on the delayed row; kernel finishes 2 cycles after win_valid rises.
      assign ack_a[gi]   = req_a[gi] && ((addr_a[gi] != delay_row) || (wait_cnt >= delay_n));
      assign rdata_a[gi] = 16'hA000 + {6'd0, addr_a[gi]};
      assign kd_a[gi]    = (valid_a[gi] && kcnt == 2) || kd_force[gi];

      always @(posedge clk or posedge rst) begin
         if (rst) begin
            wait_cnt <= 0;
            kcnt     <= 0;
         end else begin
            if (req_a[gi] && !ack_a[gi]) wait_cnt <= wait_cnt + 1;
            else                         wait_cnt <= 0;
            if (!valid_a[gi] || kd_a[gi]) kcnt <= 0;
            else                          kcnt <= kcnt + 1;
         end
      end

      always @(negedge clk) begin
         if (!rst) begin
            if (shift_a[gi])                check_event(gi, 0, line_a[gi]);
            if (valid_a[gi] && !prev_valid) check_event(gi, 1, {6'd0, crow_a[gi]});
            if (fd_a[gi])                   check_event(gi, 2, 16'd0);
         end
         prev_valid <= valid_a[gi];
      end
   end

   task automatic push(input int d, input int k, input int v);
      ev_t e;
      e.dut  = 2'(d);
      e.kind = 2'(k);
      e.val  = 16'(v);
      exp_q.push_back(e);
   endtask

   // Expected shift sequence: zero, row0, row1, then one line per advance, zero for the bottom border.
   task automatic push_frame(input int d, input int n);
      push(d, 0, 0);
      push(d, 0, 'hA000);
      push(d, 0, 'hA001);
      for (int r = 0; r < n; r++) begin
         push(d, 1, r);
         if (r + 2 <= n - 1)  push(d, 0, 'hA000 + r + 2);
         else if (r == n - 2) push(d, 0, 0);
      end
      push(d, 2, 0);
   endtask

   task automatic run_frame(input int d, input int n, input logic [9:0] drow, input int dn,
                            input bit do_start, input bit do_stray, input bit do_rst);
      int held = 0;
      bit vbad = 0, done = 0, pulsed = 0, aborted = 0, first_seen = 0;
      push_frame(d, n);
      delay_row = drow;
      delay_n   = dn;
      @(negedge clk);
      chk("idle_busy", 32'(busy_a[d]), 0);
      chk("idle_frame_done", 32'(fd_a[d]), 0);
      start_a[d] = 1'b1;
      @(negedge clk);
      start_a[d] = 1'b0;
      for (int c = 0; c < 400 && !done && !aborted; c++) begin
         kd_force[d] = 1'b0;
         start_a[d]  = 1'b0;
         if (!first_seen && req_a[d]) begin
            first_seen = 1;
            chk("first_addr", 32'(addr_a[d]), 0);
         end
         if (fd_a[d]) begin
            done = 1;
         end else begin
            if (req_a[d] && addr_a[d] == drow) begin
               held++;
               if (valid_a[d]) vbad = 1;
               if (do_stray && held == 3) kd_force[d] = 1'b1;
               if (do_rst && held == 2) begin
                  rst = 1'b1;
                  #1;
                  chk("rst_mem_req", 32'(req_a[d]), 0);
                  chk("rst_busy", 32'(busy_a[d]), 0);
                  chk("rst_win_valid", 32'(valid_a[d]), 0);
                  chk("rst_calc_row", 32'(crow_a[d]), 0);
                  chk("rst_mem_addr", 32'(addr_a[d]), 0);
                  chk("rst_win_shift", 32'(shift_a[d]), 0);
                  exp_q.delete();
                  @(posedge clk);
                  @(negedge clk);
                  rst = 1'b0;
                  aborted = 1;
               end
            end
            if (do_start && !pulsed && valid_a[d] && crow_a[d] == 10'd1) begin
               start_a[d] = 1'b1;
               pulsed = 1;
            end
            if (!aborted) @(negedge clk);
         end
      end
      kd_force[d] = 1'b0;
      start_a[d]  = 1'b0;
      if (!done && !aborted) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout dut=%0d actual=no frame_done required=frame_done", d);
      end
      if (done) begin
         chk("busy_in_done", 32'(busy_a[d]), 1);
         if (drow != 10'h3FF) begin
            chk("req_held_cycles", 32'(held), 32'(dn + 1));
            chk("valid_low_in_wait", 32'(vbad), 0);
         end
`ifdef LWS_STALL_CNT_EN
         chk("stall_cycles", stall_a[d], (int'(drow) < n) ? 32'(dn) : 32'd0);
`endif
      end
   endtask

   initial begin
      rst       = 1'b1;
      delay_row = 10'h3FF;
      delay_n   = 0;
      for (int i = 0; i < 2; i++) begin
         start_a[i]  = 1'b0;
         kd_force[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_busy", 32'(busy_a[d]), 0);
         chk("reset_mem_req", 32'(req_a[d]), 0);
         chk("reset_win_valid", 32'(valid_a[d]), 0);
         chk("reset_calc_row", 32'(crow_a[d]), 0);
         chk("reset_mem_addr", 32'(addr_a[d]), 0);
         chk("reset_frame_done", 32'(fd_a[d]), 0);
         chk("reset_win_shift", 32'(shift_a[d]), 0);
      end
      rst = 1'b0;

      run_frame(0, 4, 10'h3FF, 0, 0, 0, 0);   // plain frame
      run_frame(0, 4, 10'd2,   5, 0, 1, 0);   // row-2 ack delayed 5, stray kernel_done in FETCH
      run_frame(0, 4, 10'h3FF, 0, 1, 0, 0);   // start pulsed while presenting row 1
      run_frame(0, 4, 10'd3,   3, 0, 0, 1);   // reset during the row-3 fetch
      run_frame(0, 4, 10'h3FF, 0, 0, 0, 0);   // restart after reset
      run_frame(0, 4, 10'h3FF, 0, 0, 0, 0);   // back-to-back
      run_frame(1, 2, 10'h3FF, 0, 0, 0, 0);   // two-row frame
      run_frame(1, 2, 10'h3FF, 0, 0, 0, 0);   // back-to-back two-row frame

      @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 0);
      chk("final_busy0", 32'(busy_a[0]), 0);
      chk("final_busy1", 32'(busy_a[1]), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
